vr8b_gcla_adder: RTL and testbench

- 8-bit two-level carry-lookahead adder. Produces the 8-bit sum plus group generate (G) and group propagate (P), so a higher lookahead level computes the carry-out as COUT = G | (P & CIN).
- Leaf arithmetic block in the adder datapath. It is cascadable as one group of a 16/32-bit lookahead adder.
- Outputs are registered on one clock with an asynchronous active-low reset.

---
 rtl/adder_pkg.sv | 15 +
 rtl/cla4_group.sv | 52 +++++
 rtl/vr8b_gcla_adder.sv | 91 +++++++++
 tb/tb_vr8b_gcla_adder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared widths and types for the 8-bit two-level carry-lookahead adder.
//   GRP_W : width of one lookahead group (4 bits)
//   ADD_W : full adder width (8 bits, two groups)
//   grp_t : operand/sum slice handled by one group
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int GRP_W = 4;
    localparam int ADD_W = 8;

    typedef logic [GRP_W-1:0] grp_t;

endpackage : adder_pkg

// File: rtl/cla4_group.sv
// -----------------------------------------------------------------------------
// cla4_group
// One 4-bit carry-lookahead group. Every internal carry is produced in fully
// expanded sum-of-products form from the group carry-in, so no carry ripples
// from bit to bit inside the group.
// Ports:
//   a, b : group operands (grp_t)
//   cin  : carry into the least significant bit of the group
//   s    : group sum bits
//   gg   : group generate  (group emits a carry whatever cin is)
//   pg   : group propagate (group passes cin straight to its carry-out)
// The group's own carry-out is not produced here; the next lookahead level
// forms it from gg/pg so the cross-group carry also stays in lookahead form.
// -----------------------------------------------------------------------------
module cla4_group
    import adder_pkg::*;
(
    input  grp_t a,
    input  grp_t b,
    input  logic cin,
    output grp_t s,
    output logic gg,
    output logic pg
);

    grp_t g;
    grp_t p;
    grp_t c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

    assign gg = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;

endmodule : cla4_group

// File: rtl/vr8b_gcla_adder.sv
// -----------------------------------------------------------------------------
// vr8b_gcla_adder
// 8-bit two-level carry-lookahead adder with registered outputs. Two 4-bit
// lookahead groups produce the sum; the second level forms the cross-group
// carry and the block-level generate/propagate so that an outer lookahead
// level can compute COUT = G | (P & CIN).
// Ports:
//   CLK     : clock, rising edge
//   RESET_L : asynchronous active-low reset, clears S/G/P
//   A, B    : 8-bit addends
//   CIN     : carry into bit 0
//   S       : registered sum (A+B+CIN) mod 256
//   G       : registered block generate (independent of CIN)
//   P       : registered block propagate (independent of CIN)
// Latency is one clock; a new result is accepted every cycle.
// -----------------------------------------------------------------------------
module vr8b_gcla_adder
    import adder_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic [ADD_W-1:0] A,
    input  logic [ADD_W-1:0] B,
    input  logic             CIN,
    output logic [ADD_W-1:0] S,
    output logic             G,
    output logic             P
);

    grp_t s_lo;
    grp_t s_hi;
    logic gl;
    logic pl;
    logic gh;
    logic ph;
    logic c4;

    logic [ADD_W-1:0] s_d;
    logic             g_d;
    logic             p_d;
    logic [ADD_W-1:0] s_q;
    logic             g_q;
    logic             p_q;

    cla4_group u_grp_lo (
        .a   (A[GRP_W-1:0]),
        .b   (B[GRP_W-1:0]),
        .cin (CIN),
        .s   (s_lo),
        .gg  (gl),
        .pg  (pl)
    );

    // Carry into the high group comes from the low group's G/P, not from
    // the low group's bit-3 carry, keeping the depth position-independent.
    assign c4 = gl | (pl & CIN);

    cla4_group u_grp_hi (
        .a   (A[ADD_W-1:GRP_W]),
        .b   (B[ADD_W-1:GRP_W]),
        .cin (c4),
        .s   (s_hi),
        .gg  (gh),
        .pg  (ph)
    );

    always_comb begin
        s_d = {s_hi, s_lo};
        // Block terms never involve CIN; G and P are mutually exclusive
        // because a propagating group cannot also generate.
        g_d = gh | (ph & gl);
        p_d = ph & pl;
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            s_q <= '0;
            g_q <= 1'b0;
            p_q <= 1'b0;
        end else begin
            s_q <= s_d;
            g_q <= g_d;
            p_q <= p_d;
        end
    end

    assign S = s_q;
    assign G = g_q;
    assign P = p_q;

endmodule : vr8b_gcla_adder

// File: tb/tb_vr8b_gcla_adder.sv
// -----------------------------------------------------------------------------
// tb_vr8b_gcla_adder
// Scoreboard bench: the driver pushes the expected response of every applied
// vector into a queue; the monitor pops one entry per rising edge and compares
// it with the registered outputs. Expected values come from plain integer
// arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_vr8b_gcla_adder;

    logic       CLK;
    logic       RESET_L;
    logic [7:0] A;
    logic [7:0] B;
    logic       CIN;
    logic [7:0] S;
    logic       G;
    logic       P;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        bit         rst;
        logic [7:0] s;
        logic       g;
        logic       p;
        logic       cout;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    bit done   = 0;

    vr8b_gcla_adder dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .A       (A),
        .B       (B),
        .CIN     (CIN),
        .S       (S),
        .G       (G),
        .P       (P)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference: 9-bit arithmetic sum. G means A+B alone overflows; P means
    // A+B is exactly 255, so only a carry-in can push it over.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input bit rst);
        exp_t e;
        int   ab;
        int   sum;
        ab     = int'(a) + int'(b);
        sum    = ab + int'(cin);
        e.a    = a;
        e.b    = b;
        e.cin  = cin;
        e.rst  = rst;
        e.cout = (sum >= 256);
        if (rst) begin
            e.s = 8'h00;
            e.g = 1'b0;
            e.p = 1'b0;
        end else begin
            e.s = 8'(sum % 256);
            e.g = (ab >= 256);
            e.p = (ab == 255);
        end
        return e;
    endfunction

    task automatic check1(input string name, input logic [7:0] act,
                          input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply a vector at the falling edge; rst_lvl is the reset level that
    // will be seen at the following rising edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic rst_lvl);
        @(negedge CLK);
        RESET_L = rst_lvl;
        A       = a;
        B       = b;
        CIN     = cin;
        exp_q.push_back(model(a, b, cin, !rst_lvl));
    endtask

    // Monitor: one result per rising edge, compared just after the edge.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            txn++;
            check1("S", S, e.s);
            check1("G", {7'd0, G}, {7'd0, e.g});
            check1("P", {7'd0, P}, {7'd0, e.p});
            check1("G_and_P", {7'd0, G & P}, 8'd0);
            if (!e.rst)
                check1("COUT", {7'd0, G | (P & e.cin)}, {7'd0, e.cout});
            $display("txn %0d a=%h b=%h cin=%0d rst=%0d -> S=%h G=%0d P=%0d",
                     txn, e.a, e.b, e.cin, e.rst, S, G, P);
        end
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        RESET_L = 1'b1;
        A       = 8'h00;
        B       = 8'h00;
        CIN     = 1'b0;

        // Asynchronous reset with no clock edge yet.
        #1 RESET_L = 1'b0;
        #1;
        check1("async_rst_S", S, 8'h00);
        check1("async_rst_G", {7'd0, G}, 8'd0);
        check1("async_rst_P", {7'd0, P}, 8'd0);

        // Reset held with live inputs and running clock.
        repeat (3) drive(8'hFF, 8'h01, 1'b1, 1'b0);
        // Release: first edge gives the real result.
        drive(8'hFF, 8'h01, 1'b1, 1'b1);

        // Directed boundaries.
        drive(8'hFF, 8'h00, 1'b0, 1'b1);
        drive(8'hFF, 8'h00, 1'b1, 1'b1);
        drive(8'h80, 8'h80, 1'b0, 1'b1);
        drive(8'h0F, 8'h01, 1'b0, 1'b1);
        drive(8'h5A, 8'h3C, 1'b1, 1'b1);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        drive(8'h00, 8'h00, 1'b0, 1'b1);

        // Propagate sweep: A+B = 255 for every A.
        for (int i = 0; i < 256; i++)
            drive(8'(i), 8'(255 - i), 1'($urandom_range(0, 1)), 1'b1);

        // Back-to-back random vectors.
        for (int i = 0; i < 2000; i++)
            drive(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);

        // Random vectors held for two cycles.
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            drive(ra, rb, rc, 1'b1);
            drive(ra, rb, rc, 1'b1);
        end

        // Mid-stream reset: load a nonzero result, then drop reset between
        // edges and check the outputs clear without a clock edge.
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        @(negedge CLK);
        A   = 8'h12;
        B   = 8'h34;
        CIN = 1'b0;
        exp_q.push_back(model(8'h12, 8'h34, 1'b0, 1'b1));
        #2 RESET_L = 1'b0;
        #1;
        check1("mid_rst_S", S, 8'h00);
        check1("mid_rst_G", {7'd0, G}, 8'd0);
        drive(8'h7F, 8'h01, 1'b0, 1'b1);
        drive(8'hC3, 8'h3C, 1'b1, 1'b1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge CLK);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vr8b_gcla_adder
